// File: rtl/cm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cm_decode_pkg
// Description : Shared types and the active-low one-hot helper for cm_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cm_decode_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_SWEEP  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_SWEEP  = 2'd3
    } state_e;

    // Bits at and above 'width' come back as zero; callers truncate to width.
    function automatic logic [63:0] onehot_n(input logic [5:0] idx, input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ~(64'd1 << idx) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cm_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : cm_dwell_counter
// Description : Per-channel dwell down-counter with load, pause and expire.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic               i_pause,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_count;
    logic               w_step;

    assign w_step   = i_run & ~i_pause;
    assign o_expire = w_step & (r_count == '0);

    // A dwell of 0 behaves as 1, so both load a terminal count of 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_dwell == '0) ? '0 : i_dwell - 1'b1;
        end else if (w_step && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cm_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cm_scan_decoder
// Description : Registered active-low 1-of-N decoder with DIRECT/SCAN/SWEEP modes.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_scan_decoder
    import cm_decode_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  g1,
    input  logic                  g2a_n,
    input  logic                  g2b_n,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   y_n,
    output logic [SEL_W-1:0]      cur,
    output logic                  busy,
    output logic                  done
);

    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N - 1);
    localparam logic [1:0]       S_IDLE   = ST_IDLE;
    localparam logic [1:0]       S_DIRECT = ST_DIRECT;
    localparam logic [1:0]       S_SCAN   = ST_SCAN;
    localparam logic [1:0]       S_SWEEP  = ST_SWEEP;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] w_next_ch;
    logic [N-1:0]     r_y_n;
    logic [SEL_W-1:0] r_cur;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     w_sel_oh;
    logic [N-1:0]     w_ch_oh;
    mode_e            w_mode;
    logic             w_en;
    logic             w_expire;
    logic             w_finish;
    logic             w_walk_now;
    logic             w_walk_next;
    logic             w_enter;

    assign w_mode      = mode_e'(mode);
    assign w_en        = g1 & ~g2a_n & ~g2b_n;
    assign w_walk_now  = (r_state == S_SCAN) || (r_state == S_SWEEP);
    assign w_finish    = (r_state == S_SWEEP) && (w_mode == MODE_SWEEP) && w_expire && (r_ch == LAST_CH);

    // SWEEP is only launched from IDLE; any other mode change aborts a walk.
    always_comb begin
        w_next_state = S_IDLE;
        case (w_mode)
            MODE_DIRECT: w_next_state = S_DIRECT;
            MODE_SCAN:   w_next_state = S_SCAN;
            MODE_SWEEP: begin
                if (r_state == S_SWEEP) begin
                    w_next_state = w_finish ? S_IDLE : S_SWEEP;
                end else if ((r_state == S_IDLE) && start) begin
                    w_next_state = S_SWEEP;
                end
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    assign w_walk_next = (w_next_state == S_SCAN) || (w_next_state == S_SWEEP);
    assign w_enter     = w_walk_next && (w_next_state != r_state);

    always_comb begin
        w_next_ch = r_ch;
        if (!w_walk_next || w_enter) begin
            w_next_ch = '0;
        end else if (w_expire) begin
            w_next_ch = r_ch + 1'b1;
        end
    end

    cm_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_enter || (w_walk_next && w_expire)),
        .i_clear  (~w_walk_next),
        .i_run    (w_walk_now),
        .i_pause  (~w_en),
        .i_dwell  (dwell),
        .o_expire (w_expire)
    );

    assign w_sel_oh = N'(onehot_n(6'(sel), N));
    assign w_ch_oh  = N'(onehot_n(6'(w_next_ch), N));

    // Outputs are decoded from the next state so every change lands one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_y_n   <= '1;
            r_cur   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ch    <= w_next_ch;
            r_busy  <= w_walk_next;
            r_done  <= w_finish;
            case (w_next_state)
                S_DIRECT: begin
                    r_y_n <= w_en ? w_sel_oh : '1;
                    r_cur <= sel;
                end
                S_SCAN, S_SWEEP: begin
                    r_y_n <= w_en ? w_ch_oh : '1;
                    r_cur <= w_next_ch;
                end
                default: begin
                    r_y_n <= '1;
                    r_cur <= '0;
                end
            endcase
        end
    end

    assign y_n  = r_y_n;
    assign cur  = r_cur;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cm_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cm_scan_decoder
// Description : Scoreboard bench for cm_scan_decoder against a queue-based walk model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cm_scan_decoder;

    localparam int SEL_W = 3;
    localparam int N     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       g1 = 1'b0, g2a_n = 1'b1, g2b_n = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel = '0;
    logic       start = 1'b0;
    logic [7:0] dwell = '0;
    logic [7:0] y_n;
    logic [2:0] cur;
    logic       busy, done;

    cm_scan_decoder #(.SEL_W(SEL_W), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .sel(sel), .start(start), .dwell(dwell),
        .y_n(y_n), .cur(cur), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic [2:0] cur;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: 0 idle, 1 direct, 2 scan, 3 sweep. A walk is a queue of channel
    // numbers, one entry per asserted cycle still owed to the current channel.
    int m_st = 0;
    int q_walk[$];

    task automatic model_step(input bit r, input bit a, input bit b, input bit c,
                              input int md, input int s, input bit st, input int dw);
        exp_t e;
        bit   en;
        int   d, nst, ch;
        en = a && !b && !c;
        d  = (dw == 0) ? 1 : dw;
        e.done = 1'b0;
        if (r) begin
            m_st = 0;
            q_walk.delete();
        end else begin
            case (md)
                0: nst = 1;
                1: nst = 2;
                2: nst = (m_st == 3) ? 3 : ((m_st == 0 && st) ? 3 : 0);
                default: nst = 0;
            endcase
            if (nst >= 2 && nst != m_st) begin
                q_walk.delete();
                repeat (d) q_walk.push_back(0);
            end else if (nst >= 2 && en) begin
                ch = q_walk.pop_front();
                if (q_walk.size() == 0) begin
                    if (nst == 3 && ch == N - 1) begin
                        nst = 0;
                        e.done = 1'b1;
                    end else begin
                        repeat (d) q_walk.push_back((ch + 1) % N);
                    end
                end
            end
            if (nst < 2) q_walk.delete();
            m_st = nst;
        end
        e.y = 8'hFF; e.cur = '0; e.busy = 1'b0;
        if (m_st == 1) begin
            if (en) e.y[s] = 1'b0;
            e.cur = 3'(s);
        end else if (m_st >= 2) begin
            if (en) e.y[q_walk[0]] = 1'b0;
            e.cur = 3'(q_walk[0]);
            e.busy = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit a, input bit b, input bit c,
                       input int md, input int s, input bit st, input int dw);
        @(negedge clk);
        rst = r; g1 = a; g2a_n = b; g2b_n = c;
        mode = 2'(md); sel = 3'(s); start = st; dwell = 8'(dw);
        model_step(r, a, b, c, md, s, st, dw);
    endtask

    // Monitor: the DUT presents a registered result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (y_n === e.y && cur === e.cur && busy === e.busy && done === e.done) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t: got y_n=%h cur=%0d busy=%b done=%b, expected y_n=%h cur=%0d busy=%b done=%b",
                             $time, y_n, cur, busy, done, e.y, e.cur, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        // Reset with random other inputs
        repeat (2) cyc(1, 1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 255));

        // DIRECT: every gate combination against every select
        for (int g = 0; g < 8; g++)
            for (int s = 0; s < 8; s++)
                cyc(0, g[2], g[1], g[0], 0, s, 0, 0);

        // SCAN with dwell 2, two full laps, then abort to DIRECT
        for (int i = 0; i < 34; i++) cyc(0, 1, 0, 0, 1, 0, 0, 2);
        cyc(0, 1, 0, 0, 0, 5, 0, 2);
        cyc(0, 1, 0, 0, 0, 3, 0, 2);

        // SWEEP dwell 0 with a stray start mid-walk
        cyc(0, 1, 0, 0, 2, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 2, 0, (i == 3), 0);

        // SWEEP dwell 4 with g1 dropped for 3 edges early in channel 2
        cyc(0, 1, 0, 0, 2, 0, 1, 4);
        for (int i = 1; i < 40; i++) cyc(0, !(i >= 9 && i <= 11), 0, 0, 2, 0, 0, 4);

        // Reset mid-SWEEP
        cyc(0, 1, 0, 0, 2, 0, 1, 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 2, 0, 0, 3);
        cyc(1, 1, 0, 0, 2, 0, 0, 3);
        cyc(0, 1, 0, 0, 2, 0, 0, 3);

        // Random traffic, enables mostly on, modes biased toward walks
        for (int i = 0; i < 600; i++) begin
            int  md;
            bit  hold;
            hold = ($urandom_range(0, 9) != 0);
            md   = hold ? int'(mode) : $urandom_range(0, 3);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                md, $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
